gate_resp_checker: RTL and testbench



---
 rtl/gate_resp_checker.sv | 145 ++++++++++++++
 tb/tb_gate_resp_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_resp_checker.sv
// Response checker for a 2-input gate: accepts applied vectors, waits a settle time,
// compares the DUT output to a truth table and accumulates errors and coverage.
module gate_resp_checker #(
   parameter logic [3:0]  TRUTH_TABLE   = 4'b1000,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_a,
   input  logic             in_b,
   input  logic             in_out,
   input  logic             smp_valid,
   input  logic             smp_last,
   output logic             smp_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [3:0]       cov,
   output logic             first_err_vld,
   output logic [1:0]       first_err_idx
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_SETTLE,
      S_CHECK,
      S_DONE
   } state_t;

   // Counter runs from SETTLE_CYCLES-1 down to 0, giving exactly SETTLE_CYCLES cycles in SETTLE.
   localparam logic [3:0] SETTLE_LOAD = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

   state_t           state_q;
   logic [1:0]       vec_q;
   logic             last_q;
   logic [3:0]       settle_q;
   logic             ready_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [ERR_W-1:0] err_q;
   logic [3:0]       cov_q;
   logic             fev_q;
   logic [1:0]       fei_q;

   logic             mismatch_d;
   logic [ERR_W-1:0] err_d;
   logic [3:0]       cov_d;

   always_comb begin
      mismatch_d = (in_out != TRUTH_TABLE[vec_q]);
      err_d      = err_q;
      if (mismatch_d && (err_q != '1)) begin
         err_d = err_q + 1'b1;
      end
      cov_d        = cov_q;
      cov_d[vec_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         vec_q    <= '0;
         last_q   <= 1'b0;
         settle_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         err_q    <= '0;
         cov_q    <= '0;
         fev_q    <= 1'b0;
         fei_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_q <= S_COLLECT;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  pass_q  <= 1'b0;
                  err_q   <= '0;
                  cov_q   <= '0;
                  fev_q   <= 1'b0;
                  fei_q   <= '0;
               end
            end
            S_COLLECT: begin
               if (smp_valid && ready_q) begin
                  vec_q   <= {in_a, in_b};
                  last_q  <= smp_last;
                  ready_q <= 1'b0;
                  if (SETTLE_CYCLES == 0) begin
                     state_q <= S_CHECK;
                  end else begin
                     state_q  <= S_SETTLE;
                     settle_q <= SETTLE_LOAD;
                  end
               end
            end
            S_SETTLE: begin
               if (settle_q == '0) begin
                  state_q <= S_CHECK;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            S_CHECK: begin
               err_q <= err_d;
               cov_q <= cov_d;
               if (mismatch_d && !fev_q) begin
                  fev_q <= 1'b1;
                  fei_q <= vec_q;
               end
               // pass uses the post-check statistics so the final vector is included.
               if (last_q) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_d == '0) && (cov_d == 4'hF);
               end else begin
                  state_q <= S_COLLECT;
                  ready_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign smp_ready     = ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_cnt       = err_q;
   assign cov           = cov_q;
   assign first_err_vld = fev_q;
   assign first_err_idx = fei_q;

endmodule

// File: tb/tb_gate_resp_checker.sv
// Randomized bench for gate_resp_checker: two instances (settle 2 / 8-bit errors, settle 0 / 2-bit errors)
// checked against a sequence-level model of errors, coverage, first failure and per-vector gap.
module tb_gate_resp_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst[2], start[2], in_a[2], in_b[2], in_out[2], smp_valid[2], smp_last[2];
   logic       smp_ready[2], busy[2], done[2], pass[2], fev[2];
   logic [3:0] cov[2];
   logic [1:0] fei[2];
   logic [7:0] err0;
   logic [1:0] err1;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int unsigned settle[2]  = '{2, 0};
   int unsigned err_max[2] = '{255, 3};

   int unsigned m_err[2];
   logic [3:0]  m_cov[2];
   logic        m_fev[2];
   logic [1:0]  m_fei[2];

   gate_resp_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(2), .ERR_W(8)) u_dut_s2 (
      .clk(clk), .rst(rst[0]), .start(start[0]), .in_a(in_a[0]), .in_b(in_b[0]),
      .in_out(in_out[0]), .smp_valid(smp_valid[0]), .smp_last(smp_last[0]),
      .smp_ready(smp_ready[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .err_cnt(err0), .cov(cov[0]), .first_err_vld(fev[0]), .first_err_idx(fei[0])
   );

   gate_resp_checker #(.TRUTH_TABLE(4'b1000), .SETTLE_CYCLES(0), .ERR_W(2)) u_dut_s0 (
      .clk(clk), .rst(rst[1]), .start(start[1]), .in_a(in_a[1]), .in_b(in_b[1]),
      .in_out(in_out[1]), .smp_valid(smp_valid[1]), .smp_last(smp_last[1]),
      .smp_ready(smp_ready[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .err_cnt(err1), .cov(cov[1]), .first_err_vld(fev[1]), .first_err_idx(fei[1])
   );

   function automatic logic [7:0] err_obs(input int k);
      return (k == 0) ? err0 : {6'b0, err1};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear(input int k);
      m_err[k] = 0;
      m_cov[k] = '0;
      m_fev[k] = 1'b0;
      m_fei[k] = '0;
   endtask

   task automatic check_idle(input int k, input string tag);
      check({tag, "_ready"}, smp_ready[k], 0);
      check({tag, "_busy"}, busy[k], 0);
      check({tag, "_done"}, done[k], 0);
      check({tag, "_pass"}, pass[k], 0);
      check({tag, "_err"}, err_obs(k), 0);
      check({tag, "_cov"}, cov[k], 0);
      check({tag, "_fev"}, fev[k], 0);
      check({tag, "_fei"}, fei[k], 0);
   endtask

   task automatic do_reset(input int k);
      rst[k] = 1'b1;
      start[k] = 1'b0;
      smp_valid[k] = 1'b0;
      smp_last[k] = 1'b0;
      step();
      step();
      rst[k] = 1'b0;
      check_idle(k, "reset");
   endtask

   task automatic start_seq(input int k);
      start[k] = 1'b1;
      step();
      start[k] = 1'b0;
      model_clear(k);
      check("start_busy", busy[k], 1);
      check("start_ready", smp_ready[k], 1);
      check("start_done", done[k], 0);
      check("start_err", err_obs(k), 0);
      check("start_cov", cov[k], 0);
   endtask

   task automatic send_vec(input int k, input logic va, input logic vb, input logic wrong,
                           input logic lst, input logic toggle);
      int unsigned n;
      logic [1:0]  v;
      v = {va, vb};
      repeat ($urandom_range(0, 2)) step();
      in_a[k] = va;
      in_b[k] = vb;
      in_out[k] = (va & vb) ^ wrong;
      smp_valid[k] = 1'b1;
      smp_last[k] = lst;
      n = 0;
      while (!smp_ready[k] && n < 20) begin
         step();
         n++;
      end
      check("hs_timeout", (n < 20), 1);
      step();
      smp_valid[k] = 1'b0;
      smp_last[k] = 1'b0;
      if (wrong) begin
         if (m_err[k] < err_max[k]) m_err[k]++;
         if (!m_fev[k]) begin
            m_fev[k] = 1'b1;
            m_fei[k] = v;
         end
      end
      m_cov[k][v] = 1'b1;
      n = 0;
      while (!smp_ready[k] && !done[k] && n < 40) begin
         if (toggle) in_a[k] = ~in_a[k];
         step();
         n++;
      end
      check("gap", n, settle[k] + 1);
      check("err", err_obs(k), m_err[k]);
      check("cov", cov[k], m_cov[k]);
      check("fev", fev[k], m_fev[k]);
      check("fei", fei[k], m_fei[k]);
      check("done", done[k], lst);
   endtask

   task automatic finish_seq(input int k);
      check("end_done", done[k], 1);
      check("end_busy", busy[k], 0);
      check("end_ready", smp_ready[k], 0);
      check("end_pass", pass[k], (m_err[k] == 0) && (m_cov[k] == 4'hF));
   endtask

   task automatic full_seq(input int k, input logic [3:0] wrong_mask);
      start_seq(k);
      for (int i = 0; i < 4; i++) begin
         logic [1:0] v;
         v = 2'(i);
         send_vec(k, v[1], v[0], wrong_mask[i], (i == 3), 1'b0);
      end
      finish_seq(k);
   endtask

   task automatic rand_seq(input int k);
      int unsigned len;
      len = $urandom_range(1, 8);
      start_seq(k);
      for (int i = 0; i < int'(len); i++) begin
         logic [1:0] v;
         v = 2'($urandom_range(0, 3));
         send_vec(k, v[1], v[0], ($urandom_range(0, 3) == 0), (i == int'(len) - 1),
                  1'($urandom_range(0, 1)));
      end
      finish_seq(k);
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; start[k] = 1'b0; in_a[k] = 1'b0; in_b[k] = 1'b0;
         in_out[k] = 1'b0; smp_valid[k] = 1'b0; smp_last[k] = 1'b0;
         model_clear(k);
      end

      // Instance with settle time 2, 8-bit error counter
      do_reset(0);
      smp_valid[0] = 1'b1; in_a[0] = 1'b1; in_b[0] = 1'b1;
      repeat (3) step();
      check("idle_ignore_ready", smp_ready[0], 0);
      check("idle_ignore_cov", cov[0], 0);
      smp_valid[0] = 1'b0;

      full_seq(0, 4'b0000);
      full_seq(0, 4'b0010);
      check("err01_fei", fei[0], 2'b01);

      start_seq(0);
      send_vec(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_vec(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      finish_seq(0);
      check("partial_cov", cov[0], 4'b1001);

      start_seq(0);
      send_vec(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_vec(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      send_vec(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      finish_seq(0);

      // start together with a (wrong) vector while in DONE: vector must be dropped
      in_a[0] = 1'b1; in_b[0] = 1'b0; in_out[0] = 1'b1;
      smp_valid[0] = 1'b1; start[0] = 1'b1;
      step();
      start[0] = 1'b0; smp_valid[0] = 1'b0;
      model_clear(0);
      check("done_start_busy", busy[0], 1);
      check("done_start_done", done[0], 0);
      check("done_start_err", err_obs(0), 0);
      check("done_start_cov", cov[0], 0);
      step();
      check("done_start_ready", smp_ready[0], 1);
      send_vec(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      start[0] = 1'b1;
      step();
      start[0] = 1'b0;
      check("mid_start_busy", busy[0], 1);
      check("mid_start_err", err_obs(0), 1);
      check("mid_start_cov", cov[0], 4'b0010);
      send_vec(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_vec(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_vec(0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      finish_seq(0);

      repeat (12) rand_seq(0);

      // reset while settling
      start_seq(0);
      in_a[0] = 1'b1; in_b[0] = 1'b1; in_out[0] = 1'b0; smp_valid[0] = 1'b1;
      step();
      smp_valid[0] = 1'b0;
      check("settle_ready", smp_ready[0], 0);
      check("settle_busy", busy[0], 1);
      rst[0] = 1'b1;
      step();
      rst[0] = 1'b0;
      check_idle(0, "mid_rst");
      step();
      check("mid_rst_stay_busy", busy[0], 0);

      // Instance with no settle time, 2-bit error counter
      do_reset(1);
      start_seq(1);
      for (int i = 0; i < 5; i++) begin
         logic [1:0] v;
         v = 2'(i % 4);
         send_vec(1, v[1], v[0], 1'b1, (i == 4), 1'b0);
      end
      finish_seq(1);
      check("sat_err", err_obs(1), 3);
      check("sat_fei", fei[1], 2'b00);
      full_seq(1, 4'b0000);
      repeat (12) rand_seq(1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
